twi_reg_file: RTL
=================

# twi_reg_file

Register file and data buffering for the APB I2C (TWI) master. Sits directly downstream of the APB slave front end: it consumes the decoded `wr_en`, `rd_en`, `addr` and `wr_data` strobes and returns `rd_data`. It holds the control, prescale, slave-address and status registers, and owns a TX FIFO and an RX FIFO between the bus and the I2C bit/byte engine.

## Interface
- `APB_ADDR_WIDTH`, 8, address width from the APB front end
- `APB_DATA_WIDTH`, 32, data width
- `FIFO_DEPTH`, 4, TX and RX FIFO depth; power of two, 2 to 16
- `PRESCALE_RST`, 16'd99, reset value of PRESCALE
- `pclk`  in  1  clock; single clock domain
- `presetn`  in  1  asynchronous active-low reset
- `wr_en`  in  1  one-cycle register write strobe
- `rd_en`  in  1  one-cycle register read strobe
- `addr`  in  APB_ADDR_WIDTH  byte address; bits [4:2] decode, other bits ignored
- `wr_data`  in  APB_DATA_WIDTH  write data
- `rd_data`  out  APB_DATA_WIDTH  read data, combinational from `addr`
- `core_busy`  in  1  engine transfer in progress
- `core_ack_err`  in  1  one-cycle pulse: NACK received
- `tx_pop`  in  1  engine consumes the TX head
- `rx_push`  in  1  engine delivers a received byte
- `rx_byte`  in  8  received byte
- `tx_byte`  out  8  TX FIFO head; 0 when empty
- `tx_valid`  out  1  TX FIFO not empty
- `core_en`, `core_rw`  out  1 each  CTRL[0] and CTRL[3]
- `slv_addr`  out  7  SADDR[6:0]
- `prescale`  out  16  PRESCALE[15:0]
- `start_pulse`, `stop_pulse`  out  1 each  one-cycle command strobes
- `irq`  out  1  registered interrupt

## Operation
- Register map:
  - 0x00 CTRL: [0] en, [1] start (W, self-clearing), [2] stop (W, self-clearing), [3] rw, [4] ie. Reads return start=stop=0.
  - 0x04 PRESCALE: [15:0].
  - 0x08 SADDR: [6:0].
  - 0x0C TXDATA: write pushes `wr_data[7:0]`; reads return 0.
  - 0x10 RXDATA: read returns the head in [7:0] and pops it.
  - 0x14 STATUS: [0] busy, [1] ack_err, [2] tx_full, [3] tx_empty, [4] rx_full, [5] rx_empty, [6] tx_ovf, [7] rx_unf, [8] rx_ovf. Bits [1], [6], [7], [8] are sticky and write-1-to-clear. Other bits are read-only.
- Unmapped offsets: reads return 0, writes are ignored.
- Unused upper bits: read 0.
- Reset values:
  - CTRL=0, PRESCALE=PRESCALE_RST, SADDR=0.
  - Sticky bits 0; both FIFOs empty (pointers and count 0).
  - Outputs `start_pulse`, `stop_pulse`, `irq`, `tx_valid`, `tx_byte`, `core_en`, `core_rw`, `slv_addr` are 0; `prescale`=PRESCALE_RST.
- FIFOs:
  - Circular buffers, log2(FIFO_DEPTH)-bit pointers wrapping modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
  - TXDATA write when full with no `tx_pop` in the same cycle: data dropped, tx_ovf set.
  - TXDATA write when full with `tx_pop` in the same cycle: both occur, count unchanged.
  - `tx_pop` when empty: ignored.
  - `rx_push` when full with no RXDATA read in the same cycle: byte dropped, rx_ovf set.
  - `rx_push` when full with an RXDATA read in the same cycle: both occur.
  - RXDATA read when empty: returns 0 and sets rx_unf. A simultaneous `rx_push` is still stored.
- Commands:
  - A CTRL write with bit1=1 and the written en=1 gives `start_pulse` for one cycle. Bit2 drives `stop_pulse` the same way.
  - With en=0 written, both command bits are ignored.
  - Start and stop both set: both pulses fire in the same cycle; the engine resolves the order.
- `core_ack_err` sets ack_err. If `core_ack_err` and a W1C to ack_err occur in the same cycle, set wins. The same rule applies to every sticky bit.
- `irq` = registered ie & (ack_err | ~rx_empty).

## Timing
- Writes update state on the `pclk` edge that ends the `wr_en` cycle. Readback is valid on the next access.
- `rd_data` is purely combinational on `addr` and current state during `rd_en`. The RX pop and rx_unf update occur on the edge ending that cycle.
- `start_pulse` / `stop_pulse` are registered: high exactly one cycle, the cycle after the CTRL write edge.
- FIFO status bits, `tx_valid` and `tx_byte` reflect pointer updates one cycle after the causing edge. No bypass: a byte pushed into an empty FIFO appears at `tx_byte` the next cycle.
- `irq` lags its cause by one cycle.
- Reset asserted mid-operation clears all state immediately, including FIFO contents and in-flight pulses.
- `wr_en` and `rd_en` are never both high.

## Test plan
- Reset, then read every register → CTRL=0, PRESCALE=0x63, SADDR=0, STATUS=0x28 (tx_empty, rx_empty).
- Write TXDATA 0xA1, 0xA2, 0xA3, 0xA4, 0xA5 with FIFO_DEPTH=4 and no pops → STATUS tx_full=1, tx_ovf=1; four `tx_pop`s return 0xA1..0xA4, then tx_empty=1.
- Write CTRL=0x03 → `start_pulse` high one cycle, CTRL reads 0x01. Write CTRL=0x02 with en=0 → no pulse.
- Push 0x5C via `rx_push` with ie=1 → `irq`=1. Read RXDATA returns 0x5C, rx_empty=1, `irq` drops. A second read returns 0 and sets rx_unf; W1C 0x80 clears it.
- On a full TX FIFO, issue a TXDATA write and `tx_pop` in the same cycle → count stays 4, no tx_ovf, new byte at the tail.
- Pulse `core_ack_err` in the same cycle as a W1C of bit1 → ack_err remains 1.

Source files
------------

// File: rtl/twi_reg_file.sv
// Register file for the APB I2C master: CTRL/PRESCALE/SADDR/STATUS registers
// plus TX and RX byte FIFOs between the bus and the bit/byte engine.
module twi_reg_file #(
  parameter int unsigned APB_ADDR_WIDTH = 8,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [15:0] PRESCALE_RST   = 16'd99
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [APB_ADDR_WIDTH-1:0] addr,
  input  logic [APB_DATA_WIDTH-1:0] wr_data,
  output logic [APB_DATA_WIDTH-1:0] rd_data,
  input  logic                      core_busy,
  input  logic                      core_ack_err,
  input  logic                      tx_pop,
  input  logic                      rx_push,
  input  logic [7:0]                rx_byte,
  output logic [7:0]                tx_byte,
  output logic                      tx_valid,
  output logic                      core_en,
  output logic                      core_rw,
  output logic [6:0]                slv_addr,
  output logic [15:0]               prescale,
  output logic                      start_pulse,
  output logic                      stop_pulse,
  output logic                      irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  localparam logic [2:0] AddrCtrl     = 3'd0;
  localparam logic [2:0] AddrPrescale = 3'd1;
  localparam logic [2:0] AddrSaddr    = 3'd2;
  localparam logic [2:0] AddrTxdata   = 3'd3;
  localparam logic [2:0] AddrRxdata   = 3'd4;
  localparam logic [2:0] AddrStatus   = 3'd5;

  logic [2:0] off;
  logic       wr_ctrl, wr_pre, wr_saddr, wr_tx, wr_status, rd_rx;

  logic        en_q, rw_q, ie_q;
  logic [15:0] prescale_q;
  logic [6:0]  saddr_q;
  logic        start_q, stop_q, irq_q;
  logic        ack_err_q, tx_ovf_q, rx_unf_q, rx_ovf_q;
  logic        ack_err_d, tx_ovf_d, rx_unf_d, rx_ovf_d;

  logic [7:0]      tx_mem [FIFO_DEPTH];
  logic [7:0]      rx_mem [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic            tx_empty, tx_full, rx_empty, rx_full;
  logic            tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;
  logic [7:0]      rx_head;

  logic unused_ok;
  assign unused_ok = ^{addr[APB_ADDR_WIDTH-1:5], addr[1:0], wr_data[APB_DATA_WIDTH-1:16]};

  assign off       = addr[4:2];
  assign wr_ctrl   = wr_en & (off == AddrCtrl);
  assign wr_pre    = wr_en & (off == AddrPrescale);
  assign wr_saddr  = wr_en & (off == AddrSaddr);
  assign wr_tx     = wr_en & (off == AddrTxdata);
  assign wr_status = wr_en & (off == AddrStatus);
  assign rd_rx     = rd_en & (off == AddrRxdata);

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CntFull);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CntFull);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign tx_pop_ok  = tx_pop & ~tx_empty;
  assign tx_push_ok = wr_tx & (~tx_full | tx_pop_ok);
  assign rx_pop_ok  = rd_rx & ~rx_empty;
  assign rx_push_ok = rx_push & (~rx_full | rx_pop_ok);

  assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
  assign tx_byte  = tx_empty ? 8'h00 : tx_mem[tx_rptr_q];
  assign tx_valid = ~tx_empty;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push_ok && !tx_pop_ok) begin
      tx_cnt_d = tx_cnt_q + CntW'(1);
    end else if (!tx_push_ok && tx_pop_ok) begin
      tx_cnt_d = tx_cnt_q - CntW'(1);
    end
    rx_cnt_d = rx_cnt_q;
    if (rx_push_ok && !rx_pop_ok) begin
      rx_cnt_d = rx_cnt_q + CntW'(1);
    end else if (!rx_push_ok && rx_pop_ok) begin
      rx_cnt_d = rx_cnt_q - CntW'(1);
    end
  end

  // Sticky bits: a new event in the clearing cycle wins over the W1C.
  always_comb begin
    ack_err_d = (ack_err_q & ~(wr_status & wr_data[1])) | core_ack_err;
    tx_ovf_d  = (tx_ovf_q  & ~(wr_status & wr_data[6])) | (wr_tx & tx_full & ~tx_pop_ok);
    rx_unf_d  = (rx_unf_q  & ~(wr_status & wr_data[7])) | (rd_rx & rx_empty);
    rx_ovf_d  = (rx_ovf_q  & ~(wr_status & wr_data[8])) | (rx_push & rx_full & ~rx_pop_ok);
  end

  always_comb begin
    rd_data = '0;
    case (off)
      AddrCtrl:     rd_data[4:0]  = {ie_q, rw_q, 2'b00, en_q};
      AddrPrescale: rd_data[15:0] = prescale_q;
      AddrSaddr:    rd_data[6:0]  = saddr_q;
      AddrRxdata:   rd_data[7:0]  = rx_head;
      AddrStatus:   rd_data[8:0]  = {rx_ovf_q, rx_unf_q, tx_ovf_q, rx_empty, rx_full,
                                     tx_empty, tx_full, ack_err_q, core_busy};
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      en_q       <= 1'b0;
      rw_q       <= 1'b0;
      ie_q       <= 1'b0;
      prescale_q <= PRESCALE_RST;
      saddr_q    <= 7'd0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      irq_q      <= 1'b0;
      ack_err_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_unf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q <= wr_data[0];
        rw_q <= wr_data[3];
        ie_q <= wr_data[4];
      end
      if (wr_pre) begin
        prescale_q <= wr_data[15:0];
      end
      if (wr_saddr) begin
        saddr_q <= wr_data[6:0];
      end
      start_q   <= wr_ctrl & wr_data[0] & wr_data[1];
      stop_q    <= wr_ctrl & wr_data[0] & wr_data[2];
      irq_q     <= ie_q & (ack_err_q | ~rx_empty);
      ack_err_q <= ack_err_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_unf_q  <= rx_unf_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem[i] <= 8'h00;
        rx_mem[i] <= 8'h00;
      end
    end else begin
      if (tx_push_ok) begin
        tx_mem[tx_wptr_q] <= wr_data[7:0];
        tx_wptr_q         <= tx_wptr_q + PtrW'(1);
      end
      if (tx_pop_ok) begin
        tx_rptr_q <= tx_rptr_q + PtrW'(1);
      end
      if (rx_push_ok) begin
        rx_mem[rx_wptr_q] <= rx_byte;
        rx_wptr_q         <= rx_wptr_q + PtrW'(1);
      end
      if (rx_pop_ok) begin
        rx_rptr_q <= rx_rptr_q + PtrW'(1);
      end
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign core_en     = en_q;
  assign core_rw     = rw_q;
  assign slv_addr    = saddr_q;
  assign prescale    = prescale_q;
  assign start_pulse = start_q;
  assign stop_pulse  = stop_q;
  assign irq         = irq_q;

endmodule
